// File: rtl/gpu_instruction_queue.sv
// Staged instruction FIFO feeding the rasteriser, with show-ahead head output.
// Define GPU_QUEUE_ERR_EN to add sticky overflow/underflow flags.
module gpu_instruction_queue #(
    parameter int DEPTH       = 8,
    parameter int WORD_BITS   = 64,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [WORD_BITS-1:0]     instr_i,
    input  logic                     write_enable_i,
    input  logic                     push_instruction_i,
    input  logic                     pop_instruction_i,
    input  logic                     flush_i,
    output logic [WORD_BITS-1:0]     instr_o,
    output logic                     fifo_empty_o,
    output logic                     fifo_full_o,
    output logic                     almost_full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     staged_valid_o
`ifdef GPU_QUEUE_ERR_EN
    ,
    output logic                     overflow_o,
    output logic                     underflow_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WORD_BITS-1:0] stage_q, stage_d;
    logic                 staged_valid_q, staged_valid_d;
    logic                 empty, full, pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_instruction_i && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts
    assign push_ok = push_instruction_i && staged_valid_q && (!full || pop_ok);

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        stage_d        = stage_q;
        staged_valid_d = staged_valid_q;
        if (flush_i) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            stage_d        = '0;
            staged_valid_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d       = wr_ptr_q + 1'b1;
                staged_valid_d = 1'b0;
            end
            if (write_enable_i) begin
                stage_d        = instr_i;
                staged_valid_d = 1'b1;
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            stage_q        <= '0;
            staged_valid_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            stage_q        <= stage_d;
            staged_valid_q <= staged_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= stage_q;
    end

`ifdef GPU_QUEUE_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_instruction_i && staged_valid_q && !push_ok) overflow_d = 1'b1;
            if (pop_instruction_i && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

    assign instr_o        = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_empty_o   = empty;
    assign fifo_full_o    = full;
    assign almost_full_o  = (count_q >= CW'(AFULL_LEVEL));
    assign count_o        = count_q;
    assign staged_valid_o = staged_valid_q;

endmodule

// File: tb/tb_gpu_instruction_queue.sv
// Directed vector bench for gpu_instruction_queue (DEPTH=8, AFULL_LEVEL=6).
module tb_gpu_instruction_queue;
    localparam int DEPTH = 8;
    localparam int WB    = 64;
    localparam int AFL   = 6;

    logic          clk;
    logic          n_rst;
    logic [WB-1:0] instr_i;
    logic          we, push, pop, flush;
    logic [WB-1:0] instr_o;
    logic          empty_o, full_o, afull_o, sv_o;
    logic [3:0]    count_o;
`ifdef GPU_QUEUE_ERR_EN
    logic          ovf_o, udf_o;
`endif

    int checks   = 0;
    int failures = 0;

    gpu_instruction_queue #(.DEPTH(DEPTH), .WORD_BITS(WB), .AFULL_LEVEL(AFL)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .instr_i            (instr_i),
        .write_enable_i     (we),
        .push_instruction_i (push),
        .pop_instruction_i  (pop),
        .flush_i            (flush),
        .instr_o            (instr_o),
        .fifo_empty_o       (empty_o),
        .fifo_full_o        (full_o),
        .almost_full_o      (afull_o),
        .count_o            (count_o),
        .staged_valid_o     (sv_o)
`ifdef GPU_QUEUE_ERR_EN
        ,
        .overflow_o         (ovf_o),
        .underflow_o        (udf_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [WB-1:0] din;
        logic          push;
        logic          pop;
        logic          flush;
        int            cnt;
        logic          sv;
        logic [WB-1:0] head;
        logic          ovf;
        logic          udf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic w, input logic [WB-1:0] d, input logic pu,
                       input logic po, input logic fl, input int c,
                       input logic s, input logic [WB-1:0] h,
                       input logic ov, input logic ud);
        vec_t v;
        v.we = w; v.din = d; v.push = pu; v.pop = po; v.flush = fl;
        v.cnt = c; v.sv = s; v.head = h; v.ovf = ov; v.udf = ud;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [WB-1:0] act,
                       input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int c, input logic s,
                             input logic [WB-1:0] h, input logic ov,
                             input logic ud);
        chk({tag, " count"}, WB'(count_o), WB'(c));
        chk({tag, " empty"}, WB'(empty_o), WB'(c == 0));
        chk({tag, " full"}, WB'(full_o), WB'(c == DEPTH));
        chk({tag, " afull"}, WB'(afull_o), WB'(c >= AFL));
        chk({tag, " staged"}, WB'(sv_o), WB'(s));
        chk({tag, " head"}, instr_o, h);
`ifdef GPU_QUEUE_ERR_EN
        chk({tag, " ovf"}, WB'(ovf_o), WB'(ov));
        chk({tag, " udf"}, WB'(udf_o), WB'(ud));
`else
        if (ov === 1'bx || ud === 1'bx) $display("bad vector %s", tag);
`endif
    endtask

    task automatic drive(input logic w, input logic [WB-1:0] d,
                         input logic pu, input logic po, input logic fl);
        we = w; instr_i = d; push = pu; pop = po; flush = fl;
        @(posedge clk);
        #1;
        we = 0; push = 0; pop = 0; flush = 0;
    endtask

    initial begin
        n_rst = 0; we = 0; push = 0; pop = 0; flush = 0; instr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, '0, 0, 0);
        @(negedge clk);
        n_rst = 1;

        add(1, 64'hA5, 0, 0, 0, 0, 1, 0,     0, 0);
        add(0, 0,      1, 0, 0, 1, 0, 64'hA5, 0, 0);
        add(0, 0,      0, 1, 0, 0, 0, 0,     0, 0);
        add(1, 1,      0, 0, 0, 0, 1, 0,     0, 0);
        for (int k = 2; k <= 8; k++)
            add(1, WB'(k), 1, 0, 0, k - 1, 1, 1, 0, 0);
        add(1, 9, 1, 0, 0, 8, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 8, 1, 1, 1, 0);
        add(0, 0, 1, 1, 0, 8, 0, 2, 1, 0);
        for (int i = 1; i <= 8; i++)
            add(0, 0, 0, 1, 0, 8 - i, 0, (i < 8) ? WB'(i + 2) : '0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        add(1, 64'h33, 0, 0, 0, 0, 1, 0, 1, 1);
        add(0, 0, 1, 1, 0, 1, 0, 64'h33, 1, 1);
        add(1, 64'h40, 0, 0, 0, 1, 1, 64'h33, 1, 1);
        for (int k = 1; k <= 4; k++)
            add(1, WB'(64'h40 + k), 1, 0, 0, 1 + k, 1, 64'h33, 1, 1);
        add(1, 64'h77, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].we, vq[i].din, vq[i].push, vq[i].pop, vq[i].flush);
            chk_state($sformatf("vec%0d", i), vq[i].cnt, vq[i].sv,
                      vq[i].head, vq[i].ovf, vq[i].udf);
        end

        // Async reset mid-cycle with three entries queued
        drive(1, 64'h21, 0, 0, 0);
        drive(1, 64'h22, 1, 0, 0);
        drive(1, 64'h23, 1, 0, 0);
        drive(1, 64'h24, 1, 0, 0);
        chk_state("pre_rst", 3, 1, 64'h21, 0, 0);
        #2 n_rst = 0;
        #1;
        chk_state("async_rst", 0, 0, '0, 0, 0);
        #1 n_rst = 1;
        drive(1, 64'h11, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk_state("post_rst", 1, 0, 64'h11, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk_state("post_rst_pop", 0, 0, '0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gpu_instruction_queue.md
# gpu_instruction_queue

Parametrised instruction FIFO between the command decoder and the GPU rasteriser. Instructions are assembled in a single staging register (`write_enable_i`) and committed into the queue (`push_instruction_i`); the rasteriser consumes them head-first (`pop_instruction_i`). Successor to the fixed 8-deep field-wise instruction FIFO, adding:

- configurable depth and word width
- occupancy count and almost-full watermark
- synchronous flush
- optional sticky error flags

## Interface
Parameters:
- `DEPTH`, default 8: queue entries; power of two, minimum 2.
- `WORD_BITS`, default 64: packed instruction width (opcode, coords, radius, RGB, quad).
- `AFULL_LEVEL`, default 6: `almost_full_o` asserts when count ≥ this value; range 1..`DEPTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `instr_i`  in  `WORD_BITS`  packed instruction to stage.
- `write_enable_i`  in  1  load `instr_i` into the staging register.
- `push_instruction_i`  in  1  commit the staging register into the queue tail.
- `pop_instruction_i`  in  1  discard the head entry.
- `flush_i`  in  1  synchronous clear of queue and staging register.
- `instr_o`  out  `WORD_BITS`  head entry (show-ahead); all zeros while empty.
- `fifo_empty_o`  out  1  count == 0.
- `fifo_full_o`  out  1  count == `DEPTH`.
- `almost_full_o`  out  1  count ≥ `AFULL_LEVEL`.
- `count_o`  out  $clog2(`DEPTH`)+1  current occupancy.
- `staged_valid_o`  out  1  staging register holds an uncommitted word.
- `overflow_o`, `underflow_o`  out  1 each  sticky error flags; present only with `GPU_QUEUE_ERR_EN`.

## Operation
- Storage: `DEPTH` × `WORD_BITS` array, write/read pointers of $clog2(`DEPTH`) bits, wrapping modulo `DEPTH`. Count is held in a separate register. The array is not reset.
- Staging: when `write_enable_i`=1, the staging register ← `instr_i` and `staged_valid_o` ← 1.
- Push is accepted when `push_instruction_i`=1, `staged_valid_o`=1, and the queue is not full (or a pop is accepted in the same cycle). On acceptance: mem[wr_ptr] ← staging, wr_ptr++, `staged_valid_o` ← 0.
- Push with `staged_valid_o`=0 is ignored, with no error.
- Write and push in the same cycle: the OLD staged word is committed, the new word is staged, and `staged_valid_o` stays 1.
- Push when full with no pop: the word is dropped, the staging register is retained, and `overflow_o` is set.
- Pop is accepted when `pop_instruction_i`=1 and count > 0: rd_ptr++. Pop when empty is ignored and sets `underflow_o`.
- Simultaneous accepted push and pop: count unchanged. This is legal both when full and at any intermediate level.
- Simultaneous push and pop when empty: the push is accepted, the pop is ignored and flagged as underflow.
- `flush_i` has priority over all other inputs: pointers ← 0, count ← 0, `staged_valid_o` ← 0, error flags ← 0. A same-cycle write, push or pop is ignored.
- `instr_o` = mem[rd_ptr] when count > 0, else 0.

## Timing
- Reset (`n_rst`=0, asynchronous):
  - count, pointers, staging register ← 0
  - `fifo_empty_o`=1
  - `fifo_full_o`, `almost_full_o`, `staged_valid_o`, `overflow_o`, `underflow_o` = 0
  - `instr_o`=0
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Write at edge k → `staged_valid_o` is high after edge k. The earliest push commits at edge k+1.
- Push into an empty queue at edge k → `fifo_empty_o` falls and `instr_o` shows the word after edge k. Write-to-visible latency is therefore 2 edges.
- Pop at edge k → the next head appears on `instr_o` after edge k.
- All flags and `count_o` are registered or decoded from registered count only. They change only after a clock edge.
- Back-to-back push every cycle is supported when `write_enable_i` and `push_instruction_i` are both held high.

## Configuration
- `GPU_QUEUE_ERR_EN` defined:
  - `overflow_o` and `underflow_o` ports and their logic exist.
  - Each flag sets on its error condition, stays set until flush or reset, and is raised after the offending edge.
- `GPU_QUEUE_ERR_EN` undefined:
  - Both ports and their logic are absent.
  - Error cases keep the same data behaviour: drop, retain staging, ignore pop.

## Test plan
- Reset, then write 0xA5 and push → after the push edge: `count_o`=1, `fifo_empty_o`=0, `instr_o`=0xA5, `staged_valid_o`=0.
- Write+push words 1..8 back-to-back (DEPTH=8) → `almost_full_o` high at count 6. `fifo_full_o` high at count 8. A 9th push is dropped, `overflow_o`=1, `staged_valid_o` stays 1.
- Queue full, push word 9 and pop in the same cycle → count stays 8, `instr_o`=2. Then 8 pops return 2..9 in order, and read/write pointers wrap.
- Pop when empty → count stays 0, `instr_o`=0, `underflow_o`=1. Simultaneous push+pop when empty → count=1.
- With 5 entries queued and a word staged, assert `flush_i` together with `pop_instruction_i` → count=0, `fifo_empty_o`=1, `staged_valid_o`=0, error flags cleared.
- Drop `n_rst` asynchronously mid-cycle with 3 entries queued → all outputs reach reset values before the next edge, and a subsequent push of 0x11 is the sole entry.
